// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types for the CPU execution sequencer: FSM state encoding,
// stop-cause encoding and the width of the debug counters.
package cpu_ctrl_pkg;

    localparam int unsigned COUNT_W = 32;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        BREAK  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        BREAKPOINT = 2'd1,
        HALT_INSTR = 2'd2
    } stop_cause_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Conditions one raw active-low push-button: 2-FF synchronizer, debounce
// counter and a one-cycle pulse on an accepted released->pressed change.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (accepted level -> released)
//   key_n      raw active-low key, asynchronous to clk
//   press_evt  one-cycle pulse on the cycle the press is accepted
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;   // accepted key level, 1 = released
    logic [CW-1:0] cnt_q;
    logic          accept;

    // The sample differing from the accepted level for the last needed
    // cycle: the level flips on the coming edge.
    assign accept    = (sync_q != level_q) && (cnt_q == LAST);
    // Pulse is combinational on the accept cycle so the consumer acts on the
    // same edge the accepted level changes.
    assign press_evt = accept && !sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q <= key_n;
            sync_q <= meta_q;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller
// Execution sequencer: issues the one-cycle pipeline advance enable in
// free-run (divided), single-step or stopped modes, and keeps the cycle and
// retired-instruction counters for the debug displays.
// Ports:
//   CLOCK_50        system clock
//   resetn          asynchronous active-low reset
//   key_step_n      raw step push-button (active-low)
//   run_sw          run request switch
//   bp_enable       breakpoint compare enable
//   bp_addr, pc     breakpoint PC and current fetch PC
//   halt_instr      fetched instruction is HALT
//   wb_valid_pulse  one pulse per retired instruction
//   clr_counts      synchronous clear of both counters
//   advance         pipeline advance enable (combinational)
//   state           HALTED/STEP/RUN/BREAK
//   stop_cause      NONE/BREAKPOINT/HALT_INSTR
//   cycle_count     advance pulses issued
//   retired_count   retired instructions
module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 1,
    parameter int unsigned PC_W            = 15
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 key_step_n,
    input  logic                 run_sw,
    input  logic                 bp_enable,
    input  logic [PC_W-1:0]      bp_addr,
    input  logic [PC_W-1:0]      pc,
    input  logic                 halt_instr,
    input  logic                 wb_valid_pulse,
    input  logic                 clr_counts,
    output logic                 advance,
    output logic [1:0]           state,
    output logic [1:0]           stop_cause,
    output logic [COUNT_W-1:0]   cycle_count,
    output logic [COUNT_W-1:0]   retired_count
);

    localparam int unsigned TW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(RUN_DIV - 1);

    ctrl_state_t        state_q, state_d;
    stop_cause_t        cause_q, cause_d;
    logic               skip_bp_q, skip_bp_d;
    logic [TW-1:0]      tick_cnt_q;
    logic [COUNT_W-1:0] cycle_count_q;
    logic [COUNT_W-1:0] retired_count_q;
    logic               step_evt;
    logic               tick;
    logic               bp_hit;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_key (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .key_n     (key_step_n),
        .press_evt (step_evt)
    );

    assign tick   = (state_q == RUN) && (tick_cnt_q == TICK_LAST);
    assign bp_hit = bp_enable && (pc == bp_addr) && !skip_bp_q;

    // Divider is held at 0 outside RUN, so every RUN entry starts a fresh period.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
        end else if (state_q != RUN || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= HALTED;
            cause_q   <= NONE;
            skip_bp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            skip_bp_q <= skip_bp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        skip_bp_d = skip_bp_q;
        advance   = 1'b0;
        case (state_q)
            HALTED: begin
                if (run_sw) begin
                    state_d   = RUN;
                    cause_d   = NONE;
                    skip_bp_d = 1'b1;
                end else if (step_evt) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                advance = 1'b1;
                state_d = HALTED;
            end
            RUN: begin
                if (!run_sw) begin
                    state_d = HALTED;
                end else if (tick) begin
                    if (halt_instr) begin
                        state_d = BREAK;
                        cause_d = HALT_INSTR;
                    end else if (bp_hit) begin
                        state_d = BREAK;
                        cause_d = BREAKPOINT;
                    end else begin
                        advance   = 1'b1;
                        skip_bp_d = 1'b0;
                    end
                end
            end
            BREAK: begin
                if (step_evt) begin
                    state_d = STEP;
                end else if (!run_sw) begin
                    state_d = HALTED;
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else if (clr_counts) begin
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else begin
            if (advance) begin
                cycle_count_q <= cycle_count_q + COUNT_W'(1);
            end
            if (wb_valid_pulse) begin
                retired_count_q <= retired_count_q + COUNT_W'(1);
            end
        end
    end

    assign state         = state_q;
    assign stop_cause    = cause_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller
// Directed bench for cpu_step_controller with DEBOUNCE_CYCLES=4, RUN_DIV=3.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_cpu_step_controller;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        key_step_n;
    logic        run_sw;
    logic        bp_enable;
    logic [14:0] bp_addr;
    logic [14:0] pc;
    logic        halt_instr;
    logic        wb_valid_pulse;
    logic        clr_counts;
    logic        advance;
    logic [1:0]  state;
    logic [1:0]  stop_cause;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    int n_assert = 0;
    int n_fail   = 0;
    int adv_seen = 0;
    int adv_mark = 0;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(3),
        .PC_W(15)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .resetn         (resetn),
        .key_step_n     (key_step_n),
        .run_sw         (run_sw),
        .bp_enable      (bp_enable),
        .bp_addr        (bp_addr),
        .pc             (pc),
        .halt_instr     (halt_instr),
        .wb_valid_pulse (wb_valid_pulse),
        .clr_counts     (clr_counts),
        .advance        (advance),
        .state          (state),
        .stop_cause     (stop_cause),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Counts advance pulses as seen by the pipeline on each rising edge.
    always @(posedge CLOCK_50) begin
        if (advance === 1'b1) adv_seen <= adv_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; key_step_n = 1'b1; run_sw = 1'b0; bp_enable = 1'b0;
        bp_addr = 15'h0010; pc = 15'h0008; halt_instr = 1'b0;
        wb_valid_pulse = 1'b0; clr_counts = 1'b0;
        cyc(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cause", 32'(stop_cause), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_advance", 32'(advance), 32'd0);
        resetn = 1'b1;
        cyc(2);

        // 1: reset in the middle of RUN
        run_sw = 1'b1;
        cyc(22);
        chk("t1_run_state", 32'(state), 32'd2);
        chk("t1_run_cycles", cycle_count, 32'd7);
        #2 resetn = 1'b0;
        #1;
        chk("t1_async_state", 32'(state), 32'd0);
        chk("t1_async_cycles", cycle_count, 32'd0);
        chk("t1_async_advance", 32'(advance), 32'd0);
        run_sw = 1'b0;
        cyc(1);
        resetn = 1'b1;
        key_step_n = 1'b0;
        cyc(5);
        chk("t1_step_early", 32'(state), 32'd0);
        cyc(1);
        chk("t1_step_state", 32'(state), 32'd1);
        chk("t1_step_advance", 32'(advance), 32'd1);
        cyc(1);
        chk("t1_after_step", 32'(state), 32'd0);
        chk("t1_step_cycles", cycle_count, 32'd1);
        key_step_n = 1'b1;
        cyc(8);

        // 2: bouncing key, then a long hold
        clr_counts = 1'b1;
        cyc(1);
        clr_counts = 1'b0;
        chk("t2_clr", cycle_count, 32'd0);
        adv_mark = adv_seen;
        key_step_n = 1'b0; cyc(2);
        key_step_n = 1'b1; cyc(2);
        key_step_n = 1'b0; cyc(2);
        key_step_n = 1'b1; cyc(2);
        chk("t2_bounce_none", 32'(adv_seen - adv_mark), 32'd0);
        key_step_n = 1'b0; cyc(10);
        key_step_n = 1'b1; cyc(8);
        chk("t2_one_pulse", 32'(adv_seen - adv_mark), 32'd1);
        chk("t2_cycles", cycle_count, 32'd1);
        chk("t2_state", 32'(state), 32'd0);

        // 3: free run at divide-by-3
        clr_counts = 1'b1;
        cyc(1);
        clr_counts = 1'b0;
        adv_mark = adv_seen;
        run_sw = 1'b1;
        cyc(1);
        chk("t3_enter_run", 32'(state), 32'd2);
        cyc(1);
        chk("t3_no_adv_c2", 32'(advance), 32'd0);
        cyc(1);
        chk("t3_adv_c3", 32'(advance), 32'd1);
        cyc(28);
        chk("t3_cycles", cycle_count, 32'd10);
        run_sw = 1'b0;
        cyc(1);
        chk("t3_halted", 32'(state), 32'd0);
        cyc(5);
        chk("t3_no_more", cycle_count, 32'd10);
        chk("t3_pulses", 32'(adv_seen - adv_mark), 32'd10);

        // 4: breakpoint, step past it, re-run from the breakpointed PC
        bp_enable = 1'b1; bp_addr = 15'h0010; pc = 15'h0008;
        run_sw = 1'b1;
        cyc(4);
        chk("t4_pre_bp_cycles", cycle_count, 32'd11);
        pc = 15'h0010;
        cyc(2);
        chk("t4_bp_tick_no_adv", 32'(advance), 32'd0);
        cyc(1);
        chk("t4_break_state", 32'(state), 32'd3);
        chk("t4_break_cause", 32'(stop_cause), 32'd1);
        chk("t4_break_cycles", cycle_count, 32'd11);
        cyc(3);
        chk("t4_stay_break", 32'(state), 32'd3);
        key_step_n = 1'b0;
        cyc(6);
        chk("t4_step_state", 32'(state), 32'd1);
        chk("t4_step_adv", 32'(advance), 32'd1);
        chk("t4_step_cause", 32'(stop_cause), 32'd1);
        run_sw = 1'b0;
        cyc(1);
        chk("t4_halted", 32'(state), 32'd0);
        chk("t4_step_cycles", cycle_count, 32'd12);
        chk("t4_cause_held", 32'(stop_cause), 32'd1);
        key_step_n = 1'b1;
        cyc(8);
        run_sw = 1'b1;
        cyc(1);
        chk("t4_rerun_cause", 32'(stop_cause), 32'd0);
        cyc(2);
        chk("t4_skip_bp_adv", 32'(advance), 32'd1);
        cyc(3);
        chk("t4_second_hit", 32'(advance), 32'd0);
        chk("t4_rerun_cycles", cycle_count, 32'd13);
        cyc(1);
        chk("t4_rebreak", 32'(state), 32'd3);
        run_sw = 1'b0;
        cyc(1);
        chk("t4_break_to_halt", 32'(state), 32'd0);
        chk("t4_cause_kept", 32'(stop_cause), 32'd1);
        bp_enable = 1'b0;

        // 5: halt instruction, then step vs run_sw=0 in the same cycle
        run_sw = 1'b1;
        halt_instr = 1'b1;
        cyc(3);
        chk("t5_halt_no_adv", 32'(advance), 32'd0);
        cyc(1);
        chk("t5_break", 32'(state), 32'd3);
        chk("t5_cause", 32'(stop_cause), 32'd2);
        halt_instr = 1'b0;
        key_step_n = 1'b0;
        cyc(5);
        run_sw = 1'b0;
        cyc(1);
        chk("t5_step_wins", 32'(state), 32'd1);
        chk("t5_cause_hold", 32'(stop_cause), 32'd2);
        cyc(1);
        chk("t5_halted", 32'(state), 32'd0);
        chk("t5_cycles", cycle_count, 32'd14);
        key_step_n = 1'b1;
        cyc(8);

        // 6: counter wrap and clear priority
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_count_q;
        cyc(1);
        chk("t6_preload", cycle_count, 32'hFFFF_FFFF);
        key_step_n = 1'b0;
        cyc(7);
        chk("t6_wrap", cycle_count, 32'd0);
        key_step_n = 1'b1;
        cyc(8);
        wb_valid_pulse = 1'b1;
        cyc(3);
        wb_valid_pulse = 1'b0;
        chk("t6_retired", retired_count, 32'd3);
        wb_valid_pulse = 1'b1;
        clr_counts = 1'b1;
        cyc(1);
        wb_valid_pulse = 1'b0;
        clr_counts = 1'b0;
        chk("t6_clr_wins", retired_count, 32'd0);
        wb_valid_pulse = 1'b1;
        cyc(1);
        wb_valid_pulse = 1'b0;
        chk("t6_retired_one", retired_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
